fifo_stream_reader: RTL and testbench

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

---
 rtl/fifo_stream_reader.sv | 86 ++++++++
 tb/tb_fifo_stream_reader.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Pops words from a 1-cycle-latency FIFO into a 2-entry skid buffer and presents
// them as a valid/ready stream with burst framing and a delivered-word counter.
module fifo_stream_reader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  read_clock,
  input  logic                  read_reset,
  input  logic [DATA_WIDTH-1:0] fifo_read_data,
  input  logic                  fifo_is_empty,
  output logic                  read_enable,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [CNT_WIDTH-1:0]  word_count
);

  localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(BURST_LEN - 1);

  logic [DATA_WIDTH-1:0] buf_head;
  logic [DATA_WIDTH-1:0] buf_tail;
  logic [1:0]            occupancy;
  logic                  inflight;
  logic [BEAT_W-1:0]     beat_cnt;
  logic                  transfer;
  logic [2:0]            pending;

  assign transfer  = out_valid && out_ready;
  assign out_valid = (occupancy != 2'd0);
  assign out_data  = buf_head;
  assign out_last  = out_valid && (beat_cnt == BEAT_MAX);

  // Slots committed at the end of this cycle; a transfer frees its slot in the
  // same cycle, which is what lets a full buffer keep streaming at one word per cycle.
  always_comb begin
    pending     = {1'b0, occupancy} + {2'b00, inflight} - {2'b00, transfer};
    read_enable = read_reset && !fifo_is_empty && (pending < 3'd2);
  end

  always_ff @(posedge read_clock) begin
    if (!read_reset) begin
      occupancy  <= '0;
      inflight   <= 1'b0;
      beat_cnt   <= '0;
      word_count <= '0;
    end else begin
      inflight  <= read_enable;
      occupancy <= occupancy + {1'b0, inflight} - {1'b0, transfer};
      if (transfer) begin
        beat_cnt   <= (beat_cnt == BEAT_MAX) ? '0 : beat_cnt + 1'b1;
        word_count <= word_count + 1'b1;
      end
    end
  end

  // Data storage carries no reset: contents are only observed while out_valid is high.
  always_ff @(posedge read_clock) begin
    case ({inflight, transfer})
      2'b10: begin
        if (occupancy == 2'd0) buf_head <= fifo_read_data;
        else                   buf_tail <= fifo_read_data;
      end
      2'b01: buf_head <= buf_tail;
      2'b11: begin
        if (occupancy == 2'd1) begin
          buf_head <= fifo_read_data;
        end else begin
          buf_head <= buf_tail;
          buf_tail <= fifo_read_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge read_clock) begin
    if (read_reset) begin
      assert ({1'b0, occupancy} + {2'b00, inflight} <= 3'd2)
        else $error("buffer overcommitted: occupancy=%0d inflight=%0d", occupancy, inflight);
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: a small FIFO model with one-cycle read
// latency feeds the DUT; streamed words are collected and compared to hand-derived values.
module tb_fifo_stream_reader;

  logic       read_clock;
  logic       read_reset;
  logic [7:0] fifo_read_data;
  logic       fifo_is_empty;
  logic       read_enable;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic [3:0] word_count;

  fifo_stream_reader #(
    .DATA_WIDTH(8),
    .BURST_LEN (4),
    .CNT_WIDTH (4)
  ) dut (
    .read_clock    (read_clock),
    .read_reset    (read_reset),
    .fifo_read_data(fifo_read_data),
    .fifo_is_empty (fifo_is_empty),
    .read_enable   (read_enable),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last      (out_last),
    .word_count    (word_count)
  );

  initial read_clock = 1'b0;
  always #5 read_clock = ~read_clock;

  // FIFO model: data appears the cycle after read_enable.
  logic [7:0]  mem [0:63];
  int unsigned wr_ptr = 0;
  int unsigned rd_ptr = 0;
  logic [7:0]  staged [$];

  assign fifo_is_empty = (wr_ptr == rd_ptr);

  always @(posedge read_clock) begin
    if (read_enable) begin
      fifo_read_data <= mem[rd_ptr % 64];
      rd_ptr         <= rd_ptr + 1;
    end
  end

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [7:0]  rx_data [$];
  logic        rx_last [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic stage(input logic [7:0] d);
    staged.push_back(d);
  endtask

  // One clock cycle: inputs change just after the rising edge, outputs are
  // sampled (and accepted words recorded) on the falling edge.
  task automatic cycle(input logic rdy, input logic rst_n);
    @(posedge read_clock);
    #1;
    out_ready  = rdy;
    read_reset = rst_n;
    while (staged.size() > 0) begin
      mem[wr_ptr % 64] = staged.pop_front();
      wr_ptr++;
    end
    @(negedge read_clock);
    if (out_valid && out_ready) begin
      rx_data.push_back(out_data);
      rx_last.push_back(out_last);
    end
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    rx_data.delete();
    rx_last.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned re_cnt;
    int unsigned unstable;

    read_reset = 1'b0;
    out_ready  = 1'b0;

    // Reset state, and read_enable held low by reset even with data waiting
    do_reset();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_last", {31'd0, out_last}, 32'd0);
    check("rst_count", {28'd0, word_count}, 32'd0);
    stage(8'hA5);
    cycle(1'b1, 1'b0);
    check("rst_re_blocked", {31'd0, read_enable}, 32'd0);

    // Single word 0xA5
    cycle(1'b1, 1'b1);
    check("single_re_c0", {31'd0, read_enable}, 32'd1);
    cycle(1'b1, 1'b1);
    check("single_re_c1", {31'd0, read_enable}, 32'd0);
    check("single_valid_c1", {31'd0, out_valid}, 32'd0);
    cycle(1'b1, 1'b1);
    check("single_valid_c2", {31'd0, out_valid}, 32'd1);
    check("single_data_c2", {24'd0, out_data}, 32'hA5);
    check("single_last_c2", {31'd0, out_last}, 32'd0);
    cycle(1'b1, 1'b1);
    check("single_count", {28'd0, word_count}, 32'd1);
    check("single_valid_c3", {31'd0, out_valid}, 32'd0);

    // Streaming 0x01..0x08: valid in cycles 2..9, last on 0x04 and 0x08
    do_reset();
    for (int i = 1; i <= 8; i++) stage(8'(i));
    for (int c = 0; c <= 10; c++) begin
      cycle(1'b1, 1'b1);
      if (c >= 2 && c <= 9) begin
        check($sformatf("stream_valid_c%0d", c), {31'd0, out_valid}, 32'd1);
        check($sformatf("stream_data_c%0d", c), {24'd0, out_data}, 32'(c - 1));
        check($sformatf("stream_last_c%0d", c), {31'd0, out_last},
              (c == 5 || c == 9) ? 32'd1 : 32'd0);
      end
    end
    check("stream_valid_c10", {31'd0, out_valid}, 32'd0);
    check("stream_count", {28'd0, word_count}, 32'd8);

    // Backpressure: 10-cycle stall then drain 5 words
    do_reset();
    for (int i = 1; i <= 5; i++) stage(8'(i));
    re_cnt   = 0;
    unstable = 0;
    for (int c = 0; c < 10; c++) begin
      cycle(1'b0, 1'b1);
      if (read_enable) re_cnt++;
      if (c >= 2 && (!out_valid || out_data != 8'h01)) unstable++;
    end
    check("bp_stall_reads", re_cnt, 32'd2);
    check("bp_head_unstable_cycles", unstable, 32'd0);
    for (int c = 0; c < 30 && rx_data.size() < 5; c++) cycle(1'b1, 1'b1);
    check("bp_rx_count", rx_data.size(), 32'd5);
    for (int i = 0; i < 5 && i < rx_data.size(); i++)
      check($sformatf("bp_rx_%0d", i), {24'd0, rx_data[i]}, 32'(i + 1));
    if (rx_last.size() >= 5) begin
      check("bp_last_w4", {31'd0, rx_last[3]}, 32'd1);
      check("bp_last_w5", {31'd0, rx_last[4]}, 32'd0);
    end
    cycle(1'b1, 1'b1);
    check("bp_count", {28'd0, word_count}, 32'd5);

    // Empty glitch: FIFO goes empty right after the only pop
    do_reset();
    stage(8'h3C);
    re_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      cycle(1'b1, 1'b1);
      if (read_enable) re_cnt++;
    end
    check("glitch_reads", re_cnt, 32'd1);
    check("glitch_rx_count", rx_data.size(), 32'd1);
    if (rx_data.size() >= 1) check("glitch_rx_data", {24'd0, rx_data[0]}, 32'h3C);

    // Reset mid-stream with a full buffer and beat_cnt=1
    do_reset();
    for (int i = 0; i < 7; i++) stage(8'h11 + 8'(i));
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    check("mid_full_valid", {31'd0, out_valid}, 32'd1);
    check("mid_full_data", {24'd0, out_data}, 32'h12);
    check("mid_full_re", {31'd0, read_enable}, 32'd0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_count", {28'd0, word_count}, 32'd0);
    check("mid_rst_re", {31'd0, read_enable}, 32'd0);
    check("mid_rst_last", {31'd0, out_last}, 32'd0);
    rx_data.delete();
    rx_last.delete();
    for (int c = 0; c < 12; c++) cycle(1'b1, 1'b1);
    check("mid_rx_count", rx_data.size(), 32'd4);
    for (int i = 0; i < 4 && i < rx_data.size(); i++) begin
      check($sformatf("mid_rx_%0d", i), {24'd0, rx_data[i]}, 32'h14 + 32'(i));
      check($sformatf("mid_last_%0d", i), {31'd0, rx_last[i]}, (i == 3) ? 32'd1 : 32'd0);
    end
    check("mid_count", {28'd0, word_count}, 32'd4);

    // Counter wrap: 17 transfers on a 4-bit counter
    do_reset();
    for (int i = 0; i < 17; i++) stage(8'h40 + 8'(i));
    for (int c = 0; c < 40 && rx_data.size() < 17; c++) cycle(1'b1, 1'b1);
    check("wrap_rx_count", rx_data.size(), 32'd17);
    if (rx_data.size() >= 17) check("wrap_rx_last_word", {24'd0, rx_data[16]}, 32'h50);
    cycle(1'b1, 1'b1);
    check("wrap_count", {28'd0, word_count}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
